snn_timestep_scheduler: RTL and testbench

Sequences one time step of the spiking network. On a step request it shifts the synaptic delay lines, then walks the hidden layer and then the output layer. For each post-synaptic neuron it issues one synapse-memory address per pre-synaptic input, followed by a membrane-update strobe. It sits between the SPI configuration block, which loads weights and delays and reports cfg_busy, and the neuron/delay datapath. Step requests arrive from an external timer or a host pin.

---
 rtl/snn_timestep_scheduler.sv | 134 +++++++++++++
 tb/tb_snn_timestep_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/snn_timestep_scheduler.sv
// Time-step sequencer for the spiking network: shifts delay lines, then walks
// hidden and output neurons issuing synapse addresses and membrane updates.
module snn_timestep_scheduler #(
  parameter int N_INPUT  = 8,
  parameter int N_HIDDEN = 8,
  parameter int N_OUTPUT = 2,
  parameter int ADDR_W   = 8,
  parameter int IDX_W    = 4
) (
  input  logic              system_clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              step_req,
  input  logic              cfg_busy,
  input  logic              overrun_clr,
  output logic              busy,
  output logic              delay_shift,
  output logic              layer_sel,
  output logic [IDX_W-1:0]  post_idx,
  output logic [IDX_W-1:0]  pre_idx,
  output logic [ADDR_W-1:0] syn_addr,
  output logic              syn_valid,
  output logic              acc_clear,
  output logic              neuron_update,
  output logic              step_done,
  output logic [15:0]       step_count,
  output logic              overrun
);

  typedef enum logic [2:0] {IDLE, SHIFT, ACC, UPDATE, DONE} state_t;

  localparam logic [IDX_W-1:0]  LAST_PRE_H  = IDX_W'(N_INPUT - 1);
  localparam logic [IDX_W-1:0]  LAST_PRE_O  = IDX_W'(N_HIDDEN - 1);
  localparam logic [IDX_W-1:0]  LAST_POST_H = IDX_W'(N_HIDDEN - 1);
  localparam logic [IDX_W-1:0]  LAST_POST_O = IDX_W'(N_OUTPUT - 1);
  localparam logic [ADDR_W-1:0] OUT_BASE    = ADDR_W'(N_INPUT * N_HIDDEN);
  localparam logic [ADDR_W-1:0] STRIDE_H    = ADDR_W'(N_INPUT);
  localparam logic [ADDR_W-1:0] STRIDE_O    = ADDR_W'(N_HIDDEN);

  state_t             state, state_nxt;
  logic               layer_nxt;
  logic [IDX_W-1:0]   post_nxt, pre_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic               overrun_set;

  always_comb begin
    state_nxt   = state;
    layer_nxt   = layer_sel;
    post_nxt    = post_idx;
    pre_nxt     = pre_idx;
    overrun_set = step_req && ((state != IDLE) || (enable && cfg_busy));
    unique case (state)
      IDLE: begin
        layer_nxt = 1'b0;
        post_nxt  = '0;
        pre_nxt   = '0;
        if (step_req && enable && !cfg_busy) state_nxt = SHIFT;
      end
      SHIFT: begin
        layer_nxt = 1'b0;
        post_nxt  = '0;
        pre_nxt   = '0;
        state_nxt = ACC;
      end
      ACC: begin
        if (pre_idx == (layer_sel ? LAST_PRE_O : LAST_PRE_H)) state_nxt = UPDATE;
        else pre_nxt = pre_idx + 1'b1;
      end
      UPDATE: begin
        pre_nxt = '0;
        if (post_idx != (layer_sel ? LAST_POST_O : LAST_POST_H)) begin
          post_nxt  = post_idx + 1'b1;
          state_nxt = ACC;
        end else if (!layer_sel) begin
          layer_nxt = 1'b1;
          post_nxt  = '0;
          state_nxt = ACC;
        end else begin
          layer_nxt = 1'b0;
          post_nxt  = '0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        layer_nxt = 1'b0;
        post_nxt  = '0;
        pre_nxt   = '0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address is computed from the next indices so syn_addr lands with syn_valid.
  always_comb begin
    addr_nxt = (layer_nxt ? OUT_BASE : '0)
             + ADDR_W'(post_nxt) * (layer_nxt ? STRIDE_O : STRIDE_H)
             + ADDR_W'(pre_nxt);
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state         <= IDLE;
      layer_sel     <= 1'b0;
      post_idx      <= '0;
      pre_idx       <= '0;
      syn_addr      <= '0;
      busy          <= 1'b0;
      delay_shift   <= 1'b0;
      syn_valid     <= 1'b0;
      acc_clear     <= 1'b0;
      neuron_update <= 1'b0;
      step_done     <= 1'b0;
      step_count    <= '0;
      overrun       <= 1'b0;
    end else begin
      state         <= state_nxt;
      layer_sel     <= layer_nxt;
      post_idx      <= post_nxt;
      pre_idx       <= pre_nxt;
      syn_addr      <= (state_nxt == ACC) ? addr_nxt : '0;
      busy          <= (state_nxt != IDLE);
      delay_shift   <= (state_nxt == SHIFT);
      syn_valid     <= (state_nxt == ACC);
      acc_clear     <= (state_nxt == ACC) && (pre_nxt == '0);
      neuron_update <= (state_nxt == UPDATE);
      step_done     <= (state_nxt == DONE);
      if (state == DONE) step_count <= step_count + 16'd1;
      if (overrun_set) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Randomized and directed bench for snn_timestep_scheduler, checked every cycle
// against a model that derives outputs from the cycle offset within a step.
module tb_snn_timestep_scheduler;
  localparam int NI = 8, NH = 8, NO = 2, AW = 8, IW = 4;
  localparam int LAT = 1 + NH * (NI + 1) + NO * (NH + 1) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, step_req = 1'b0, cfg_busy = 1'b0, overrun_clr = 1'b0;
  logic busy, delay_shift, layer_sel, syn_valid, acc_clear, neuron_update, step_done, overrun;
  logic [IW-1:0] post_idx, pre_idx;
  logic [AW-1:0] syn_addr;
  logic [15:0] step_count;

  snn_timestep_scheduler #(.N_INPUT(NI), .N_HIDDEN(NH), .N_OUTPUT(NO), .ADDR_W(AW), .IDX_W(IW)) dut (
    .system_clock(clk), .reset(reset), .enable(enable), .step_req(step_req),
    .cfg_busy(cfg_busy), .overrun_clr(overrun_clr), .busy(busy), .delay_shift(delay_shift),
    .layer_sel(layer_sel), .post_idx(post_idx), .pre_idx(pre_idx), .syn_addr(syn_addr),
    .syn_valid(syn_valid), .acc_clear(acc_clear), .neuron_update(neuron_update),
    .step_done(step_done), .step_count(step_count), .overrun(overrun));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_t is the cycle number since acceptance (0 = idle).
  int m_t = 0, m_cnt = 0;
  bit m_ovr = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_t = 0; m_cnt = 0; m_ovr = 0;
    end else begin
      if (step_req && (m_t > 0 || (enable && cfg_busy))) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
      if (m_t == LAT) begin
        m_t = 0; m_cnt = (m_cnt + 1) % 65536;
      end else if (m_t > 0) m_t = m_t + 1;
      else if (step_req && enable && !cfg_busy) m_t = 1;
    end
  end

  int k, r, n, base, e_post, e_pre, e_addr, sv_cnt, nu_cnt, nxt_addr;
  bit e_valid, e_upd, e_layer;

  always @(negedge clk) if (chk_en) begin
    e_valid = 0; e_upd = 0; e_layer = 0; e_post = 0; e_pre = 0; e_addr = 0;
    if (m_t >= 2 && m_t < LAT) begin
      k = m_t - 2;
      if (k < NH * (NI + 1)) begin
        n = NI; base = 0; e_layer = 0;
      end else begin
        k = k - NH * (NI + 1); n = NH; base = NI * NH; e_layer = 1;
      end
      e_post = k / (n + 1); r = k % (n + 1);
      if (r < n) begin
        e_valid = 1; e_pre = r; e_addr = base + e_post * n + r;
      end else e_upd = 1;
    end
    chk("busy", busy, m_t > 0);
    chk("delay_shift", delay_shift, m_t == 1);
    chk("syn_valid", syn_valid, e_valid);
    chk("acc_clear", acc_clear, e_valid && e_pre == 0);
    chk("neuron_update", neuron_update, e_upd);
    chk("step_done", step_done, m_t == LAT);
    chk("step_count", step_count, m_cnt);
    chk("overrun", overrun, m_ovr);
    if (e_valid || e_upd) begin
      chk("layer_sel", layer_sel, e_layer);
      chk("post_idx", post_idx, e_post);
    end
    if (e_valid) begin
      chk("pre_idx", pre_idx, e_pre);
      chk("syn_addr", syn_addr, e_addr);
    end
    if (m_t == 0) chk("idle_idx", {layer_sel, post_idx, pre_idx, syn_addr}, 0);
    // Hand-computed pins on the default geometry.
    if (m_t == 1) begin sv_cnt = 0; nu_cnt = 0; nxt_addr = 0; end
    if (m_t > 0 && syn_valid) begin
      chk("addr_seq", syn_addr, nxt_addr);
      nxt_addr++; sv_cnt++;
    end
    if (m_t > 0 && neuron_update) nu_cnt++;
    if (m_t == 2) begin chk("first_addr", syn_addr, 0); chk("first_clr", acc_clear, 1); end
    if (m_t == 10) chk("first_update", neuron_update, 1);
    if (m_t == 90) begin chk("last_addr", syn_addr, 79); chk("last_layer", layer_sel, 1); end
    if (m_t == 92) begin
      chk("done_at_92", step_done, 1);
      chk("valid_total", sv_cnt, 80);
      chk("update_total", nu_cnt, 10);
    end
  end

  task automatic tick(input int c);
    repeat (c) @(negedge clk);
  endtask

  task automatic pulse_req();
    step_req = 1; tick(1); step_req = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) tick(1);
    if (busy) chk("idle_timeout", busy, 0);
  endtask

  initial begin
    tick(1); chk_en = 1; tick(2);
    chk("reset_count", step_count, 0);
    reset = 0; enable = 1; tick(2);
    // Single step: latency, addresses, totals
    pulse_req(); wait_idle();
    chk("count_1", step_count, 1);
    // Request at cycle 40, then clear together with a request while busy
    pulse_req(); tick(39);
    pulse_req(); chk("ovr_mid", overrun, 1);
    overrun_clr = 1; step_req = 1; tick(1); overrun_clr = 0; step_req = 0;
    chk("ovr_set_wins", overrun, 1);
    wait_idle(); chk("count_2", step_count, 2);
    overrun_clr = 1; tick(1); overrun_clr = 0; chk("ovr_cleared", overrun, 0);
    // cfg_busy at acceptance, then enable low
    cfg_busy = 1; pulse_req(); cfg_busy = 0;
    chk("cfg_no_busy", busy, 0); chk("cfg_ovr", overrun, 1);
    overrun_clr = 1; tick(1); overrun_clr = 0;
    enable = 0; pulse_req(); tick(2); enable = 1;
    chk("en0_busy", busy, 0); chk("en0_ovr", overrun, 0);
    // Request in the DONE cycle is dropped
    pulse_req(); tick(91); pulse_req();
    chk("done_req_ovr", overrun, 1); chk("done_req_idle", busy, 0);
    overrun_clr = 1; tick(1); overrun_clr = 0;
    // Reset mid-step
    pulse_req(); tick(49); reset = 1; tick(1); reset = 0;
    chk("rst_busy", busy, 0); chk("rst_count", step_count, 0);
    pulse_req(); wait_idle(); chk("rst_then_1", step_count, 1);
    // Step counter wrap
    @(posedge clk); #1;
    dut.step_count = 16'hFFFF; m_cnt = 65535;
    @(negedge clk);
    pulse_req(); wait_idle(); chk("wrap", step_count, 0);
    // Randomized traffic
    for (int i = 0; i < 5000; i++) begin
      step_req    = ($urandom % 25) == 0;
      enable      = ($urandom % 8) != 0;
      cfg_busy    = ($urandom % 6) == 0;
      overrun_clr = ($urandom % 12) == 0;
      reset       = ($urandom % 900) == 0;
      tick(1);
    end
    step_req = 0; overrun_clr = 0; reset = 0; cfg_busy = 0;
    tick(1); wait_idle(); tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
